// File: rtl/matmul_tile_scheduler_pkg.sv
// Shared definitions for the matmul tile scheduler, multiply sequencer and accumulation table.
// Array geometry defaults, scheduler state encoding and tile sizing helpers.
package matmul_tile_scheduler_pkg;

  localparam int DEF_SYS_ARR_HEIGHT = 16;
  localparam int DEF_SYS_ARR_WIDTH  = 16;
  localparam int DEF_MAX_OUT_ROWS   = 128;
  localparam int DEF_MAX_OUT_COLS   = 128;
  localparam int DEF_MAX_K          = 128;
  localparam int DEF_ADDR_WIDTH     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // Edge tiles carry the remainder; an exact multiple keeps the full tile.
  function automatic int unsigned tile_size(input int unsigned dim, input int unsigned full);
    int unsigned rem;
    rem = dim % full;
    return (rem == 0) ? full : rem;
  endfunction

  function automatic int unsigned tile_count(input int unsigned dim, input int unsigned full);
    return (dim + full - 1) / full;
  endfunction

endpackage

// File: rtl/matmul_tile_scheduler_tile_index_counter.sv
// Nested it/kt/jt tile counters (it innermost, jt outermost) with incrementally
// stepped weight/data addresses and registered per-tile sizes.
module matmul_tile_scheduler_tile_index_counter #(
  parameter int SYS_ARR_HEIGHT = 16,
  parameter int SYS_ARR_WIDTH  = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int IW             = 3,
  parameter int KW             = 3,
  parameter int JW             = 3,
  parameter int RW             = 5,
  parameter int CW             = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_advance,
  input  logic [IW-1:0]         i_last_it,
  input  logic [KW-1:0]         i_last_kt,
  input  logic [JW-1:0]         i_last_jt,
  input  logic [RW-1:0]         i_edge_rows,
  input  logic [CW-1:0]         i_edge_cols,
  input  logic [RW-1:0]         i_edge_depth,
  input  logic [ADDR_WIDTH-1:0] i_w_stride,
  input  logic [ADDR_WIDTH-1:0] i_d_stride,
  input  logic [ADDR_WIDTH-1:0] i_base_weight,
  input  logic [ADDR_WIDTH-1:0] i_base_data,
  output logic [IW-1:0]         o_it,
  output logic [JW-1:0]         o_jt,
  output logic [ADDR_WIDTH-1:0] o_weight_addr,
  output logic [ADDR_WIDTH-1:0] o_data_addr,
  output logic [RW-1:0]         o_rows,
  output logic [CW-1:0]         o_cols,
  output logic [RW-1:0]         o_depth,
  output logic                  o_accum,
  output logic                  o_last
);

  localparam logic [RW-1:0]         FULL_ROWS = RW'(SYS_ARR_HEIGHT);
  localparam logic [CW-1:0]         FULL_COLS = CW'(SYS_ARR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(SYS_ARR_HEIGHT);

  logic [IW-1:0]         r_it, r_last_it;
  logic [KW-1:0]         r_kt, r_last_kt;
  logic [JW-1:0]         r_jt, r_last_jt;
  logic [RW-1:0]         r_edge_rows, r_edge_depth;
  logic [CW-1:0]         r_edge_cols;
  logic [ADDR_WIDTH-1:0] r_w_stride, r_d_stride, r_base_data;
  logic [ADDR_WIDTH-1:0] r_w_col_base, r_d_kt_base;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_it <= '0; r_kt <= '0; r_jt <= '0;
      r_last_it <= '0; r_last_kt <= '0; r_last_jt <= '0;
      r_edge_rows <= '0; r_edge_cols <= '0; r_edge_depth <= '0;
      r_w_stride <= '0; r_d_stride <= '0; r_base_data <= '0;
      r_w_col_base <= '0; r_d_kt_base <= '0;
      o_weight_addr <= '0; o_data_addr <= '0;
      o_rows <= '0; o_cols <= '0; o_depth <= '0; o_accum <= 1'b0;
    end else if (i_load) begin
      r_it <= '0; r_kt <= '0; r_jt <= '0;
      r_last_it <= i_last_it; r_last_kt <= i_last_kt; r_last_jt <= i_last_jt;
      r_edge_rows <= i_edge_rows; r_edge_cols <= i_edge_cols; r_edge_depth <= i_edge_depth;
      r_w_stride <= i_w_stride; r_d_stride <= i_d_stride; r_base_data <= i_base_data;
      r_w_col_base <= i_base_weight; r_d_kt_base <= i_base_data;
      o_weight_addr <= i_base_weight; o_data_addr <= i_base_data;
      o_rows  <= (i_last_it == '0) ? i_edge_rows  : FULL_ROWS;
      o_cols  <= (i_last_jt == '0) ? i_edge_cols  : FULL_COLS;
      o_depth <= (i_last_kt == '0) ? i_edge_depth : FULL_ROWS;
      o_accum <= 1'b0;
    end else if (i_advance) begin
      if (r_it != r_last_it) begin
        r_it        <= r_it + 1'b1;
        o_data_addr <= o_data_addr + r_d_stride;
        o_rows      <= ((r_it + 1'b1) == r_last_it) ? r_edge_rows : FULL_ROWS;
      end else begin
        r_it   <= '0;
        o_rows <= (r_last_it == '0) ? r_edge_rows : FULL_ROWS;
        if (r_kt != r_last_kt) begin
          r_kt          <= r_kt + 1'b1;
          o_accum       <= 1'b1;
          o_weight_addr <= o_weight_addr + r_w_stride;
          r_d_kt_base   <= r_d_kt_base + STEP;
          o_data_addr   <= r_d_kt_base + STEP;
          o_depth       <= ((r_kt + 1'b1) == r_last_kt) ? r_edge_depth : FULL_ROWS;
        end else begin
          // Next output column block: weight walks back to kt=0, data restarts at the base.
          r_kt          <= '0;
          o_accum       <= 1'b0;
          o_depth       <= (r_last_kt == '0) ? r_edge_depth : FULL_ROWS;
          r_jt          <= r_jt + 1'b1;
          r_w_col_base  <= r_w_col_base + STEP;
          o_weight_addr <= r_w_col_base + STEP;
          r_d_kt_base   <= r_base_data;
          o_data_addr   <= r_base_data;
          o_cols        <= ((r_jt + 1'b1) == r_last_jt) ? r_edge_cols : FULL_COLS;
        end
      end
    end
  end

  assign o_it   = r_it;
  assign o_jt   = r_jt;
  assign o_last = (r_it == r_last_it) && (r_kt == r_last_kt) && (r_jt == r_last_jt);

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Splits one M x N x K matmul job into array-sized tiles and issues them one at a time.
//   state | meaning
//   IDLE  | wait for start    ISSUE | tile_valid high    WAIT | tile accepted, wait tile_done    DONE | done pulse
module matmul_tile_scheduler
  import matmul_tile_scheduler_pkg::*;
#(
  parameter int SYS_ARR_HEIGHT = DEF_SYS_ARR_HEIGHT,
  parameter int SYS_ARR_WIDTH  = DEF_SYS_ARR_WIDTH,
  parameter int MAX_OUT_ROWS   = DEF_MAX_OUT_ROWS,
  parameter int MAX_OUT_COLS   = DEF_MAX_OUT_COLS,
  parameter int MAX_K          = DEF_MAX_K,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           i_start,
  input  logic [$clog2(MAX_OUT_ROWS):0]                  i_m_rows,
  input  logic [$clog2(MAX_OUT_COLS):0]                  i_n_cols,
  input  logic [$clog2(MAX_K):0]                         i_k_depth,
  input  logic [ADDR_WIDTH-1:0]                          i_base_weight,
  input  logic [ADDR_WIDTH-1:0]                          i_base_data,
  output logic                                           o_busy,
  output logic                                           o_done,
  output logic                                           o_err,
  output logic                                           o_tile_valid,
  input  logic                                           i_tile_ready,
  input  logic                                           i_tile_done,
  output logic [ADDR_WIDTH-1:0]                          o_tile_weight_addr,
  output logic [ADDR_WIDTH-1:0]                          o_tile_data_addr,
  output logic [$clog2(SYS_ARR_HEIGHT):0]                o_tile_rows,
  output logic [$clog2(SYS_ARR_WIDTH):0]                 o_tile_cols,
  output logic [$clog2(SYS_ARR_HEIGHT):0]                o_tile_depth,
  output logic                                           o_tile_accum,
  output logic [$clog2(MAX_OUT_ROWS/SYS_ARR_HEIGHT)-1:0] o_accum_submat_row,
  output logic [$clog2(MAX_OUT_COLS/SYS_ARR_WIDTH)-1:0]  o_accum_submat_col
);

  localparam int IW    = $clog2(MAX_OUT_ROWS / SYS_ARR_HEIGHT);
  localparam int JW    = $clog2(MAX_OUT_COLS / SYS_ARR_WIDTH);
  localparam int KW    = $clog2(MAX_K / SYS_ARR_HEIGHT);
  localparam int RW    = $clog2(SYS_ARR_HEIGHT) + 1;
  localparam int CW    = $clog2(SYS_ARR_WIDTH) + 1;
  localparam int LOG_H = $clog2(SYS_ARR_HEIGHT);

  sched_state_e          r_state;
  logic                  w_dims_ok, w_load, w_advance, w_last;
  logic [IW-1:0]         w_last_it;
  logic [KW-1:0]         w_last_kt;
  logic [JW-1:0]         w_last_jt;
  logic [RW-1:0]         w_edge_rows, w_edge_depth;
  logic [CW-1:0]         w_edge_cols;
  logic [ADDR_WIDTH-1:0] w_w_stride, w_d_stride;

  assign w_dims_ok = (i_m_rows != '0) && (32'(i_m_rows) <= MAX_OUT_ROWS) &&
                     (i_n_cols != '0) && (32'(i_n_cols) <= MAX_OUT_COLS) &&
                     (i_k_depth != '0) && (32'(i_k_depth) <= MAX_K);

  assign w_last_it    = IW'(tile_count(32'(i_m_rows), SYS_ARR_HEIGHT) - 1);
  assign w_last_jt    = JW'(tile_count(32'(i_n_cols), SYS_ARR_WIDTH) - 1);
  assign w_last_kt    = KW'(tile_count(32'(i_k_depth), SYS_ARR_HEIGHT) - 1);
  assign w_edge_rows  = RW'(tile_size(32'(i_m_rows), SYS_ARR_HEIGHT));
  assign w_edge_cols  = CW'(tile_size(32'(i_n_cols), SYS_ARR_WIDTH));
  assign w_edge_depth = RW'(tile_size(32'(i_k_depth), SYS_ARR_HEIGHT));
  // Address strides: one kt step moves NT weight tiles, one it step moves KT data tiles.
  assign w_w_stride   = ADDR_WIDTH'(tile_count(32'(i_n_cols), SYS_ARR_WIDTH) << LOG_H);
  assign w_d_stride   = ADDR_WIDTH'(tile_count(32'(i_k_depth), SYS_ARR_HEIGHT) << LOG_H);

  assign w_load    = (r_state == ST_IDLE) && i_start && w_dims_ok;
  assign w_advance = (r_state == ST_WAIT) && i_tile_done && !w_last;

  matmul_tile_scheduler_tile_index_counter #(
    .SYS_ARR_HEIGHT(SYS_ARR_HEIGHT), .SYS_ARR_WIDTH(SYS_ARR_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .IW(IW), .KW(KW), .JW(JW), .RW(RW), .CW(CW)
  ) u_tile_index_counter (
    .clk           (clk),
    .reset         (reset),
    .i_load        (w_load),
    .i_advance     (w_advance),
    .i_last_it     (w_last_it),
    .i_last_kt     (w_last_kt),
    .i_last_jt     (w_last_jt),
    .i_edge_rows   (w_edge_rows),
    .i_edge_cols   (w_edge_cols),
    .i_edge_depth  (w_edge_depth),
    .i_w_stride    (w_w_stride),
    .i_d_stride    (w_d_stride),
    .i_base_weight (i_base_weight),
    .i_base_data   (i_base_data),
    .o_it          (o_accum_submat_row),
    .o_jt          (o_accum_submat_col),
    .o_weight_addr (o_tile_weight_addr),
    .o_data_addr   (o_tile_data_addr),
    .o_rows        (o_tile_rows),
    .o_cols        (o_tile_cols),
    .o_depth       (o_tile_depth),
    .o_accum       (o_tile_accum),
    .o_last        (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_tile_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            o_err  <= 1'b0;
            o_busy <= 1'b1;
            if (w_dims_ok) begin
              r_state      <= ST_ISSUE;
              o_tile_valid <= 1'b1;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_ISSUE: begin
          if (i_tile_ready) begin
            o_tile_valid <= 1'b0;
            r_state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_tile_done) begin
            if (w_last) begin
              r_state <= ST_DONE;
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
            end else begin
              r_state      <= ST_ISSUE;
              o_tile_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          // A rejected job arrives here without done raised; emit it with err first.
          if (o_done) begin
            o_done  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            o_err  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
